// File: rtl/plant_pkg.sv
// Shared types and helpers for the first-order-plus-dead-time plant emulator.
// Also holds the LFSR constants used when PLANT_NOISE_EN is defined.
package plant_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int SAT_W = 64;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11 mapped onto a right-shifting register: bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            saturate = hi;
        end else if (v < lo) begin
            saturate = lo;
        end else begin
            saturate = v;
        end
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/plant_delay_line.sv
// Circular dead-time buffer: read at wp-dly before the same-tick write at wp.
// A delay of zero bypasses the storage entirely.
module plant_delay_line
    import plant_pkg::*;
#(
    parameter int  DATA_W    = 16,
    parameter int  DELAY_MAX = 16,
    localparam int AW        = $clog2(DELAY_MAX)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [AW-1:0]            dly,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] dout
);

    logic signed [DATA_W-1:0] mem [DELAY_MAX];
    logic [AW-1:0]            wp_q;
    logic [AW-1:0]            wp_d;
    logic [AW-1:0]            rp_s;

    // Write pointer advance and read address / bypass select.
    always_comb begin
        wp_d = wp_q;
        if (we) begin
            wp_d = wp_q + AW'(1);
        end else begin
            wp_d = wp_q;
        end
        rp_s = wp_q - dly;
        if (dly == '0) begin
            dout = din;
        end else begin
            dout = mem[rp_s];
        end
    end

    // Write pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q <= '0;
        end else begin
            wp_q <= wp_d;
        end
    end

    // Storage carries no reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wp_q] <= din;
        end
    end

endmodule

// File: rtl/plant_emulator.sv
// First-order-plus-dead-time plant: tick divider, FILL/RUN state machine, saturating integrator.
// Define PLANT_NOISE_EN to add LFSR noise on process_variable.
module plant_emulator
    import plant_pkg::*;
#(
    parameter int  DATA_W      = 16,
    parameter int  DELAY_MAX   = 16,
    parameter int  TICK_DIV    = 4,
    parameter int  ALPHA_SHIFT = 3,
    parameter int  GAIN_SHIFT  = 0,
    parameter int  PV_INIT     = 0,
    parameter int  NOISE_BITS  = 4,
    localparam int DLY_W       = $clog2(DELAY_MAX)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [DLY_W-1:0]         delay_cfg,
    input  logic signed [DATA_W-1:0] control_in,
    output logic signed [DATA_W-1:0] process_variable,
    output logic                     pv_valid,
    output logic                     sat_flag,
    output logic                     running
);

    localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW  = DATA_W + 3;
    localparam logic signed [DATA_W-1:0] PV_RST = DATA_W'(PV_INIT);

    state_e                   state_q, state_d;
    logic [TCW-1:0]           tick_cnt_q, tick_cnt_d;
    logic [DLY_W-1:0]         fill_cnt_q, fill_cnt_d;
    logic [DLY_W-1:0]         dly_q, dly_d;
    logic signed [DATA_W-1:0] y_q, y_d;
    logic signed [DATA_W-1:0] pv_q, pv_d;
    logic                     pv_valid_q, pv_valid_d;
    logic                     sat_q, sat_d;
    logic                     running_q, running_d;

    logic                     tick_s;
    logic                     we_s;
    logic signed [DATA_W-1:0] u_d_s;
    logic signed [TW-1:0]     target_s;
    logic signed [TW:0]       diff_s;
    logic signed [TW:0]       step_s;
    logic signed [SAT_W-1:0]  sum_s;
    logic signed [SAT_W-1:0]  y_sat_s;
    logic signed [DATA_W-1:0] y_next_s;
    logic                     y_clamp_s;
    logic signed [DATA_W-1:0] y_out_s;
    logic signed [DATA_W-1:0] pv_cand_s;
    logic                     pv_clamp_s;

    assign tick_s = enable && (tick_cnt_q == TCW'(TICK_DIV - 1));

    plant_delay_line #(
        .DATA_W    (DATA_W),
        .DELAY_MAX (DELAY_MAX)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .we    (we_s),
        .dly   (dly_q),
        .din   (control_in),
        .dout  (u_d_s)
    );

    // Integrator step; floor shift means small positive errors stall while negative ones always move.
    always_comb begin
        target_s  = TW'(u_d_s) <<< GAIN_SHIFT;
        diff_s    = (TW + 1)'(target_s) - (TW + 1)'(y_q);
        step_s    = diff_s >>> ALPHA_SHIFT;
        sum_s     = SAT_W'(y_q) + SAT_W'(step_s);
        y_sat_s   = saturate(sum_s, DATA_W);
        y_next_s  = y_sat_s[DATA_W-1:0];
        y_clamp_s = (y_sat_s != sum_s);
        if (state_q == RUN) begin
            y_out_s = y_next_s;
        end else begin
            y_out_s = y_q;
        end
    end

`ifdef PLANT_NOISE_EN
    logic [15:0]             lfsr_q, lfsr_d;
    logic signed [SAT_W-1:0] pv_sum_s;
    logic signed [SAT_W-1:0] pv_sat_s;

    // Noise is added only on the output path; y itself stays clean.
    always_comb begin
        if (tick_s) begin
            lfsr_d = lfsr_step(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
        pv_sum_s   = SAT_W'(y_out_s) + SAT_W'(signed'(lfsr_q[NOISE_BITS-1:0]));
        pv_sat_s   = saturate(pv_sum_s, DATA_W);
        pv_cand_s  = pv_sat_s[DATA_W-1:0];
        pv_clamp_s = (pv_sat_s != pv_sum_s);
    end

    // LFSR state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    // Output path without noise.
    always_comb begin
        pv_cand_s  = y_out_s;
        pv_clamp_s = 1'b0;
    end
`endif

    // Tick divider and IDLE/FILL/RUN next-state logic.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        fill_cnt_d = fill_cnt_q;
        dly_d      = dly_q;
        y_d        = y_q;
        pv_d       = pv_q;
        pv_valid_d = 1'b0;
        sat_d      = sat_q;
        we_s       = 1'b0;
        if (!enable) begin
            tick_cnt_d = '0;
            state_d    = IDLE;
        end else begin
            if (tick_s) begin
                tick_cnt_d = '0;
            end else begin
                tick_cnt_d = tick_cnt_q + TCW'(1);
            end
            case (state_q)
                IDLE: begin
                    dly_d      = delay_cfg;
                    fill_cnt_d = '0;
                    if (delay_cfg == '0) begin
                        state_d = RUN;
                    end else begin
                        state_d = FILL;
                    end
                end
                FILL: begin
                    if (tick_s) begin
                        we_s       = 1'b1;
                        fill_cnt_d = fill_cnt_q + DLY_W'(1);
                        pv_d       = pv_cand_s;
                        pv_valid_d = 1'b1;
                        sat_d      = pv_clamp_s;
                        if (fill_cnt_d == dly_q) begin
                            state_d = RUN;
                        end else begin
                            state_d = FILL;
                        end
                    end else begin
                        state_d = FILL;
                    end
                end
                RUN: begin
                    if (tick_s) begin
                        we_s       = 1'b1;
                        y_d        = y_next_s;
                        pv_d       = pv_cand_s;
                        pv_valid_d = 1'b1;
                        sat_d      = y_clamp_s | pv_clamp_s;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        running_d = (state_d == RUN);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            fill_cnt_q <= '0;
            dly_q      <= '0;
            y_q        <= PV_RST;
            pv_q       <= PV_RST;
            pv_valid_q <= 1'b0;
            sat_q      <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            fill_cnt_q <= fill_cnt_d;
            dly_q      <= dly_d;
            y_q        <= y_d;
            pv_q       <= pv_d;
            pv_valid_q <= pv_valid_d;
            sat_q      <= sat_d;
            running_q  <= running_d;
        end
    end

    assign process_variable = pv_q;
    assign pv_valid         = pv_valid_q;
    assign sat_flag         = sat_q;
    assign running          = running_q;

endmodule

// File: doc/plant_emulator.md
Name: plant_emulator

Overview:
- Discrete first-order-plus-dead-time process model: consumes the PID controller's signed control output and produces the signed process variable fed back to it.
- Closes the control loop in simulation and on FPGA without a physical plant.
- Sample-rate divider, circular dead-time buffer, fill/run state machine, saturating integrator.

Parameters:
- DATA_W, 16: width of control_in and process_variable (signed).
- DELAY_MAX, 16: dead-time buffer depth, power of 2; legal delay 0..DELAY_MAX-1 ticks.
- TICK_DIV, 4: clk cycles per plant sample tick (>=1).
- ALPHA_SHIFT, 3: time-constant shift; step = (target - y) >>> ALPHA_SHIFT.
- GAIN_SHIFT, 0: plant DC gain as a left shift of the delayed input (0..2).
- PV_INIT, 0: process_variable value after reset.
- NOISE_BITS, 4: noise magnitude bits (used only with PLANT_NOISE_EN).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run plant; low = hold state
- delay_cfg  in  $clog2(DELAY_MAX)  dead time in ticks; latched on IDLE->FILL
- control_in  in  DATA_W signed  actuator command, sampled on tick
- process_variable  out  DATA_W signed  registered plant output
- pv_valid  out  1  one-cycle pulse per update
- sat_flag  out  1  last update clamped
- running  out  1  state==RUN

Behaviour:
- Reset (async, active-high): state IDLE, tick counter 0, write pointer 0, fill counter 0, y=PV_INIT, process_variable=PV_INIT, pv_valid=0, sat_flag=0, running=0. Buffer contents are not reset; FILL masks them.
- Tick counter: counts 0..TICK_DIV-1 only while enable=1. Tick asserts when count==TICK_DIV-1, then wraps to 0. enable=0 clears the counter.
- IDLE: enable=1 -> FILL; latch delay_cfg into dly. If dly==0, go directly to RUN.
- FILL: on each tick, write control_in, increment fill counter, keep y unchanged, pulse pv_valid. When fill counter reaches dly -> RUN.
- RUN: on each tick, read u_d, write control_in, update y, pulse pv_valid.
- enable=0 in any state -> IDLE on the next cycle. y is held. Re-enable restarts FILL; the buffer is treated as stale.
- Delay line: circular buffer. Write at wp, then wp=(wp+1) mod DELAY_MAX. Read u_d at (wp-dly) mod DELAY_MAX before the same-tick write. dly==0 bypasses the buffer: u_d=control_in.
- Update arithmetic:
  - target = u_d <<< GAIN_SHIFT (DATA_W+3 signed).
  - diff = target - y.
  - step = diff >>> ALPHA_SHIFT (arithmetic, floor).
  - y_next = y + step, clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - sat_flag = clamp occurred.
  - Truncation bias: small positive diffs stall (u=7,y=0 with shift 3 stays 0); negative diffs always move at least 1.
- Latency: process_variable and pv_valid update on the clk edge after the tick cycle.
- delay_cfg changes outside IDLE are ignored.
- Reset mid-run aborts immediately; no partial update is visible.

Optional Feature:
- Macro PLANT_NOISE_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11, seed 16'hACE1 on reset, advanced every tick.
  - process_variable = sat(y + sext(lfsr[NOISE_BITS-1:0])), signed interpretation.
  - Internal y stays noise-free.
  - sat_flag also covers the output clamp.
- Undefined: no LFSR logic; process_variable = y; NOISE_BITS unused.

Decomposition:
- Package plant_pkg:
  - state enum {IDLE, FILL, RUN}.
  - Saturate function (width-generic via parameter).
  - LFSR seed and tap constants.
- Sub-module plant_delay_line: circular buffer with wp, read-before-write, dly==0 bypass. Synthesisable to distributed RAM.

Test Plan:
- Defaults, delay_cfg=0, control_in=800 held, enable=1 -> first pv_valid after 4 clks, pv=100, then 187, 263; running=1 from the first cycle after enable.
- delay_cfg=3, control_in steps 0->800 at enable -> pv=0 for 3 pv_valid pulses (FILL), pv=100 on the 4th pulse.
- control_in=-800, delay 0 -> pv=-100, then -188; control_in=7 from y=0 -> pv stays 0.
- GAIN_SHIFT=2, ALPHA_SHIFT=0, control_in=20000 -> pv=32767, sat_flag=1; control_in=-20000 -> pv=-32768, sat_flag=1.
- reset asserted mid-RUN for 1 clk -> pv=PV_INIT and pv_valid=0 immediately (async); after re-enable with delay_cfg=2, FILL repeats for 2 ticks.
- PLANT_NOISE_EN, control_in=0, y=0 -> pv sequence equals sign-extended low 4 LFSR bits from seed ACE1; internal y stays 0.
